// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
package fb_pkg;

   typedef enum logic [0:0] {
      FB_IDLE  = 1'b0,
      FB_CLEAR = 1'b1
   } fb_state_t;

   typedef logic bank_sel_t;

   localparam int FB_BANKS                 = 2;
   localparam int FB_DEFAULT_ADDRESS_WIDTH = 20;
   localparam int CLR_CNT_W                = FB_DEFAULT_ADDRESS_WIDTH;

endpackage

// File: rtl/dp_ram_bank.sv
// One frame bank: synchronous write port plus a registered read port that
// holds its last value when no read is issued.
module dp_ram_bank
   import fb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = CLR_CNT_W,
   parameter int DATA_WIDTH    = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     re,
   input  logic [ADDRESS_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: display reads the front bank, renderer and clear
// engine write the back bank, banks swap only on a frame boundary.
module pingpong_frame_buffer
   import fb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 20,
   parameter int DATA_WIDTH    = 15,
   parameter int PIXELS        = 2**ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     WRITE_EN,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic                     WR_READY,
   input  logic                     READ_EN,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    RGB,
   output logic                     RD_VALID,
   input  logic                     SWAP_REQ,
   input  logic                     FRAME_START,
   output logic                     SWAP_PENDING,
   output logic                     FRONT_SEL,
   input  logic                     CLEAR_REQ,
   input  logic [DATA_WIDTH-1:0]    clear_color,
   output logic                     CLEAR_BUSY,
   output fb_state_t                fsm_state
);

   localparam logic [ADDRESS_WIDTH-1:0] CLR_LAST = ADDRESS_WIDTH'(PIXELS - 1);

   fb_state_t                state;
   bank_sel_t                front_sel;
   bank_sel_t                back_sel;
   bank_sel_t                rd_bank_q;
   logic                     swap_pending_q;
   logic                     rd_valid_q;
   logic [ADDRESS_WIDTH-1:0] clr_cnt;
   logic [DATA_WIDTH-1:0]    clr_color_q;
   logic                     clear_busy;
   logic                     do_swap;
   logic                     wr_en_mux;
   logic [ADDRESS_WIDTH-1:0] wr_addr_mux;
   logic [DATA_WIDTH-1:0]    wr_data_mux;
   logic [DATA_WIDTH-1:0]    bank_rdata [FB_BANKS];

   assign clear_busy = (state == FB_CLEAR);
   assign back_sel   = ~front_sel;

   // A swap is held off while the back bank is being cleared.
   assign do_swap = FRAME_START && (swap_pending_q || SWAP_REQ) && !clear_busy;

   // Host writes are dropped while the clear engine owns the write port.
   assign wr_en_mux   = clear_busy || WRITE_EN;
   assign wr_addr_mux = clear_busy ? clr_cnt     : wr_addr;
   assign wr_data_mux = clear_busy ? clr_color_q : din;

   for (genvar b = 0; b < FB_BANKS; b++) begin : g_bank
      dp_ram_bank #(
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .DATA_WIDTH    (DATA_WIDTH)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (wr_en_mux && (back_sel == bank_sel_t'(b))),
         .waddr (wr_addr_mux),
         .wdata (wr_data_mux),
         .re    (READ_EN && (front_sel == bank_sel_t'(b))),
         .raddr (rd_addr),
         .rdata (bank_rdata[b])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         front_sel      <= 1'b0;
         swap_pending_q <= 1'b0;
         rd_bank_q      <= 1'b0;
         rd_valid_q     <= 1'b0;
      end else begin
         rd_valid_q <= READ_EN;
         if (READ_EN) begin
            rd_bank_q <= front_sel;
         end
         if (do_swap) begin
            front_sel      <= ~front_sel;
            swap_pending_q <= 1'b0;
         end else if (SWAP_REQ) begin
            swap_pending_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FB_IDLE;
         clr_cnt     <= '0;
         clr_color_q <= '0;
      end else begin
         case (state)
            FB_IDLE: begin
               if (CLEAR_REQ) begin
                  state       <= FB_CLEAR;
                  clr_cnt     <= '0;
                  clr_color_q <= clear_color;
               end
            end
            FB_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CLR_LAST) begin
                  state <= FB_IDLE;
               end
            end
            default: state <= FB_IDLE;
         endcase
      end
   end

   assign RGB          = bank_rdata[rd_bank_q];
   assign RD_VALID     = rd_valid_q;
   assign SWAP_PENDING = swap_pending_q;
   assign FRONT_SEL    = front_sel;
   assign CLEAR_BUSY   = clear_busy;
   assign WR_READY     = ~clear_busy;
   assign fsm_state    = state;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer with a 16-entry, 12-pixel clear.
module tb_pingpong_frame_buffer;
   import fb_pkg::*;

   localparam int AW     = 4;
   localparam int DW     = 15;
   localparam int NPIX   = 12;
   localparam int DEPTH  = 16;

   logic          clk;
   logic          rst;
   logic          WRITE_EN;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] din;
   logic          WR_READY;
   logic          READ_EN;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] RGB;
   logic          RD_VALID;
   logic          SWAP_REQ;
   logic          FRAME_START;
   logic          SWAP_PENDING;
   logic          FRONT_SEL;
   logic          CLEAR_REQ;
   logic [DW-1:0] clear_color;
   logic          CLEAR_BUSY;
   fb_state_t     fsm_state;

   int n_checks;
   int n_fail;
   logic [DW-1:0] exp_q[$];

   pingpong_frame_buffer #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .PIXELS        (NPIX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .WRITE_EN     (WRITE_EN),
      .wr_addr      (wr_addr),
      .din          (din),
      .WR_READY     (WR_READY),
      .READ_EN      (READ_EN),
      .rd_addr      (rd_addr),
      .RGB          (RGB),
      .RD_VALID     (RD_VALID),
      .SWAP_REQ     (SWAP_REQ),
      .FRAME_START  (FRAME_START),
      .SWAP_PENDING (SWAP_PENDING),
      .FRONT_SEL    (FRONT_SEL),
      .CLEAR_REQ    (CLEAR_REQ),
      .clear_color  (clear_color),
      .CLEAR_BUSY   (CLEAR_BUSY),
      .fsm_state    (fsm_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int a, input int d);
      WRITE_EN = 1'b1;
      wr_addr  = AW'(a);
      din      = DW'(d);
      step();
      WRITE_EN = 1'b0;
   endtask

   task automatic fill_back(input int base);
      for (int i = 0; i < DEPTH; i++) begin
         write_word(i, base + i);
      end
   endtask

   task automatic pulse_swap_now();
      SWAP_REQ    = 1'b1;
      FRAME_START = 1'b1;
      step();
      SWAP_REQ    = 1'b0;
      FRAME_START = 1'b0;
   endtask

   // Reads are pipelined; each result is compared against the scoreboard head.
   task automatic read_sweep(input string tag, input int lo, input int hi);
      READ_EN = 1'b1;
      for (int a = lo; a <= hi; a++) begin
         rd_addr = AW'(a);
         step();
         if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
         end else begin
            check_eq(tag, {17'd0, RGB}, {17'd0, exp_q.pop_front()});
         end
         check_eq({tag, "_valid"}, {31'd0, RD_VALID}, 32'd1);
      end
      READ_EN = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_front"},   {31'd0, FRONT_SEL},    32'd0);
      check_eq({tag, "_rgb"},     {17'd0, RGB},          32'd0);
      check_eq({tag, "_rdvalid"}, {31'd0, RD_VALID},     32'd0);
      check_eq({tag, "_pending"}, {31'd0, SWAP_PENDING}, 32'd0);
      check_eq({tag, "_busy"},    {31'd0, CLEAR_BUSY},   32'd0);
      check_eq({tag, "_wrready"}, {31'd0, WR_READY},     32'd1);
      check_eq({tag, "_state"},   {31'd0, fsm_state},    {31'd0, FB_IDLE});
   endtask

   initial begin
      int busy_cycles;
      int guard;

      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      WRITE_EN    = 1'b0;
      wr_addr     = '0;
      din         = '0;
      READ_EN     = 1'b0;
      rd_addr     = '0;
      SWAP_REQ    = 1'b0;
      FRAME_START = 1'b0;
      CLEAR_REQ   = 1'b0;
      clear_color = '0;

      repeat (2) step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Basic write, swap, read
      write_word(3, 'h1234);
      SWAP_REQ = 1'b1;
      step();
      SWAP_REQ = 1'b0;
      check_eq("basic_pending", {31'd0, SWAP_PENDING}, 32'd1);
      check_eq("basic_front_before", {31'd0, FRONT_SEL}, 32'd0);
      FRAME_START = 1'b1;
      step();
      FRAME_START = 1'b0;
      check_eq("basic_front_after", {31'd0, FRONT_SEL}, 32'd1);
      check_eq("basic_pending_clr", {31'd0, SWAP_PENDING}, 32'd0);
      exp_q.push_back(DW'('h1234));
      read_sweep("basic_rgb", 3, 3);
      step();
      check_eq("basic_rdvalid_drop", {31'd0, RD_VALID}, 32'd0);
      check_eq("basic_rgb_hold", {17'd0, RGB}, 32'h1234);

      // Isolation: writes land in the back bank only
      write_word(3, 'h7FFF);
      exp_q.push_back(DW'('h1234));
      read_sweep("iso_rgb", 3, 3);

      // Deferred swap with a repeated request while pending
      fill_back('h100);
      SWAP_REQ = 1'b1;
      step();
      SWAP_REQ = 1'b0;
      for (int c = 6; c < 20; c++) begin
         check_eq("defer_pending", {31'd0, SWAP_PENDING}, 32'd1);
         check_eq("defer_front_hold", {31'd0, FRONT_SEL}, 32'd1);
         SWAP_REQ = (c == 10);
         step();
      end
      SWAP_REQ    = 1'b0;
      FRAME_START = 1'b1;
      step();
      FRAME_START = 1'b0;
      check_eq("defer_front_swap", {31'd0, FRONT_SEL}, 32'd0);
      check_eq("defer_pending_clr", {31'd0, SWAP_PENDING}, 32'd0);
      FRAME_START = 1'b1;
      step();
      FRAME_START = 1'b0;
      check_eq("defer_single_swap", {31'd0, FRONT_SEL}, 32'd0);
      exp_q.push_back(DW'('h103));
      read_sweep("defer_rgb", 3, 3);

      // Clear: exact busy length, host write dropped, colour latched
      fill_back('h200);
      clear_color = DW'('h001F);
      CLEAR_REQ   = 1'b1;
      step();
      CLEAR_REQ   = 1'b0;
      clear_color = DW'('h0777);
      wr_addr     = AW'(12);
      din         = DW'('h5555);
      busy_cycles = 0;
      guard       = 0;
      while (CLEAR_BUSY && guard < 100) begin
         busy_cycles++;
         guard++;
         if (busy_cycles == 1) begin
            check_eq("clear_wrready_low", {31'd0, WR_READY}, 32'd0);
            check_eq("clear_state", {31'd0, fsm_state}, {31'd0, FB_CLEAR});
         end
         WRITE_EN  = (busy_cycles == 3);
         CLEAR_REQ = (busy_cycles == 5);
         step();
      end
      WRITE_EN  = 1'b0;
      CLEAR_REQ = 1'b0;
      check_eq("clear_busy_cycles", busy_cycles, NPIX);
      check_eq("clear_wrready_high", {31'd0, WR_READY}, 32'd1);
      pulse_swap_now();
      check_eq("clear_front", {31'd0, FRONT_SEL}, 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back((i < NPIX) ? DW'('h001F) : DW'('h200 + i));
      end
      read_sweep("clear_rgb", 0, DEPTH - 1);

      // Clear blocks a pending swap
      SWAP_REQ = 1'b1;
      step();
      SWAP_REQ    = 1'b0;
      clear_color = DW'('h0ABC);
      CLEAR_REQ   = 1'b1;
      step();
      CLEAR_REQ = 1'b0;
      repeat (3) step();
      FRAME_START = 1'b1;
      step();
      FRAME_START = 1'b0;
      check_eq("block_front_hold", {31'd0, FRONT_SEL}, 32'd1);
      check_eq("block_pending_hold", {31'd0, SWAP_PENDING}, 32'd1);
      check_eq("block_busy", {31'd0, CLEAR_BUSY}, 32'd1);
      guard = 0;
      while (CLEAR_BUSY && guard < 100) begin
         guard++;
         step();
      end
      check_eq("block_busy_fell", {31'd0, CLEAR_BUSY}, 32'd0);
      check_eq("block_front_after_clear", {31'd0, FRONT_SEL}, 32'd1);
      check_eq("block_pending_after_clear", {31'd0, SWAP_PENDING}, 32'd1);
      FRAME_START = 1'b1;
      step();
      FRAME_START = 1'b0;
      check_eq("block_front_swap", {31'd0, FRONT_SEL}, 32'd0);
      check_eq("block_pending_clr", {31'd0, SWAP_PENDING}, 32'd0);
      exp_q.push_back(DW'('h0ABC));
      exp_q.push_back(DW'('h0ABC));
      exp_q.push_back(DW'('h10C));
      exp_q.push_back(DW'('h10D));
      read_sweep("block_rgb", 10, 13);

      // Asynchronous reset four fill writes into a clear
      fill_back('h300);
      SWAP_REQ = 1'b1;
      step();
      SWAP_REQ = 1'b0;
      check_eq("abort_pending_set", {31'd0, SWAP_PENDING}, 32'd1);
      clear_color = DW'('h001F);
      CLEAR_REQ   = 1'b1;
      READ_EN     = 1'b1;
      rd_addr     = AW'(0);
      step();
      CLEAR_REQ = 1'b0;
      repeat (4) step();
      check_eq("abort_rgb_pre", {17'd0, RGB}, 32'h0ABC);
      check_eq("abort_busy_pre", {31'd0, CLEAR_BUSY}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      READ_EN = 1'b0;
      step();
      rst = 1'b0;
      step();
      pulse_swap_now();
      check_eq("abort_front", {31'd0, FRONT_SEL}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back((i < 4) ? DW'('h001F) : DW'('h300 + i));
      end
      read_sweep("abort_rgb", 0, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pingpong_frame_buffer.md
# pingpong_frame_buffer

Double-buffered, parametrised successor to the single-bank pixel RAM. It holds two frame banks. The display side reads the front bank while the renderer writes the back bank, and the banks swap only at a frame boundary, so the display never tears. A built-in clear engine fills the back bank with a constant colour, one pixel per cycle.

## Interface
Parameters:
- ADDRESS_WIDTH, 20, address bits per bank
- DATA_WIDTH, 15, pixel width (RGB555)
- PIXELS, 2**ADDRESS_WIDTH, number of pixels the clear engine covers (1..2**ADDRESS_WIDTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- WRITE_EN  in  1  write din to back bank at wr_addr
- wr_addr  in  ADDRESS_WIDTH  write address
- din  in  DATA_WIDTH  write data
- WR_READY  out  1  high when host writes are accepted (equals ~CLEAR_BUSY)
- READ_EN  in  1  read front bank at rd_addr
- rd_addr  in  ADDRESS_WIDTH  read address
- RGB  out  DATA_WIDTH  registered read data
- RD_VALID  out  1  RGB carries the data of a read issued the previous cycle
- SWAP_REQ  in  1  one-cycle request to swap banks at the next frame boundary
- FRAME_START  in  1  one-cycle frame-boundary pulse from display timing
- SWAP_PENDING  out  1  swap requested, not yet performed
- FRONT_SEL  out  1  index of the bank currently displayed
- CLEAR_REQ  in  1  one-cycle request to clear the back bank
- clear_color  in  DATA_WIDTH  fill value, sampled with CLEAR_REQ
- CLEAR_BUSY  out  1  clear engine active

## Operation
- Reset values:
  - FRONT_SEL=0, RGB=0, RD_VALID=0.
  - SWAP_PENDING=0, CLEAR_BUSY=0, WR_READY=1.
  - FSM in FB_IDLE, clear counter 0.
  - RAM contents are not reset.
- Reads:
  - Always from bank FRONT_SEL.
  - RGB is updated only when READ_EN=1; otherwise it holds its value.
  - RD_VALID is READ_EN delayed one cycle.
- Host writes:
  - Always target bank ~FRONT_SEL.
  - A write with WRITE_EN=1 while CLEAR_BUSY=1 is dropped silently.
- Swap:
  - SWAP_REQ sets SWAP_PENDING.
  - On a cycle with FRAME_START=1, SWAP_PENDING or SWAP_REQ high, and CLEAR_BUSY=0: FRONT_SEL toggles and SWAP_PENDING clears.
  - Repeated SWAP_REQ while pending has no further effect (one swap only).
- FSM states:
  - FB_IDLE: CLEAR_REQ moves to FB_CLEAR; clear_color is latched and the counter is set to 0.
  - FB_CLEAR: each cycle writes the latched colour to back-bank address counter, then increments the counter. After the write at PIXELS-1, returns to FB_IDLE.
  - CLEAR_REQ in FB_CLEAR is ignored.
- Clear/swap interaction: FRAME_START with a pending swap during FB_CLEAR does not swap. The swap waits for the first FRAME_START after CLEAR_BUSY falls, so the bank being cleared never becomes visible mid-clear.
- Reset mid-clear: clear aborts immediately and the bank is left partially filled; a pending swap is discarded.

## Timing
- Read latency 1 cycle: READ_EN at edge N, then RGB/RD_VALID valid after edge N+1. Throughput is one read per cycle.
- Write visible to a read of the same bank from the cycle after the write edge.
- Same-bank read/write collisions cannot occur, because reads and writes always target different banks.
- Swap cycle: FRONT_SEL changes at the edge sampling FRAME_START. Reads and writes issued in that same cycle use the old selection.
- Clear:
  - CLEAR_REQ sampled at edge N: CLEAR_BUSY=1 and WR_READY=0 after edge N.
  - First fill write (address 0) at edge N+1; last (address PIXELS-1) at edge N+PIXELS.
  - CLEAR_BUSY=0 after edge N+PIXELS.
  - Total busy duration is exactly PIXELS cycles.
- Simultaneous CLEAR_REQ and swap at the same FRAME_START (idle): the swap happens first, and the clear targets the new back bank (the old front).

## Structure
- Package fb_pkg holds:
  - fb_state_t enum {FB_IDLE, FB_CLEAR};
  - bank_sel_t (1-bit typedef);
  - localparams FB_BANKS=2 and CLR_CNT_W=ADDRESS_WIDTH.
- Sub-module dp_ram_bank: one simple dual-port synchronous RAM (write port and registered read port, parametrised ADDRESS_WIDTH/DATA_WIDTH), instantiated twice.
- The top level muxes write/read enables and addresses per bank, selects RGB by a registered FRONT_SEL copy, and contains the FSM.

## Test plan
Bench parameters: ADDRESS_WIDTH=4, DATA_WIDTH=15, PIXELS=12.
- Reset/basic: after reset, write 0x1234 to addr 3, SWAP_REQ, then FRAME_START. Read addr 3 the next cycle: RGB=0x1234 one cycle later, RD_VALID=1, FRONT_SEL=1.
- Isolation: with FRONT_SEL=1, write 0x7FFF to addr 3 and read addr 3. RGB must stay the front-bank value 0x1234 until the next swap.
- Deferred swap: SWAP_REQ at cycle 5, FRAME_START at cycle 20. SWAP_PENDING=1 for cycles 6–20; FRONT_SEL toggles only after the cycle-20 edge.
- Clear: CLEAR_REQ with clear_color=0x001F. CLEAR_BUSY stays high exactly 12 cycles, and a WRITE_EN during that window is dropped. After swap, addresses 0–11 read 0x001F and addresses 12–15 keep their prior contents.
- Clear blocks swap: SWAP_REQ, CLEAR_REQ, then FRAME_START during the clear. No swap occurs; the swap happens at the first FRAME_START after CLEAR_BUSY falls.
- Async reset mid-clear: assert rst on clear cycle 4. All outputs return to their reset values immediately; the bank shows 0x001F at addresses 0–3 only.
